// File: rtl/prio_encoder_4to2_seq.sv
// prio_encoder_4to2_seq: captures request pulses and issues their indices, highest first, one per handshake
module prio_encoder_4to2_seq #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          e,
  input  logic [N-1:0]  req,
  output logic [W-1:0]  y,
  output logic          valid,
  input  logic          ready,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] drop_cnt
);
  logic [W-1:0] sel;
  logic [N-1:0] clr;
  logic         load;
  logic         fire;
  logic         drop;
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++)
      if (pending[i]) sel = W'(i);
  end
  assign fire = valid & ready;
  assign load = e & (|pending) & (~valid | ready);
  assign clr  = load ? (N'(1) << sel) : '0;
  assign drop = e & (|(req & pending & ~clr));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      valid    <= 1'b0;
      y        <= '0;
      drop_cnt <= '0;
    end else begin
      pending <= (pending & ~clr) | (req & {N{e}});
      if (load) begin
        valid <= 1'b1;
        y     <= sel;
      end else if (fire) begin
        valid <= 1'b0;
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_prio_encoder_4to2_seq.sv
// tb_prio_encoder_4to2_seq: directed vector table plus saturation and mid-transfer reset sequences
module tb_prio_encoder_4to2_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       e = 1'b1;
  logic [3:0] req = 4'hf;
  logic       ready = 1'b0;
  logic [1:0] y;
  logic       valid;
  logic [3:0] pending;
  logic [7:0] drop_cnt;
  int         cnt = 0;
  int         errs = 0;
  typedef struct {
    logic       rst_n;
    logic       e;
    logic [3:0] req;
    logic       ready;
    logic [3:0] p;
    logic       v;
    logic [1:0] y;
    logic [7:0] d;
  } vec_t;
  vec_t tv[$];
  prio_encoder_4to2_seq dut (
    .clk(clk), .rst_n(rst_n), .e(e), .req(req), .y(y), .valid(valid),
    .ready(ready), .pending(pending), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int got, input int exp);
    cnt++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int p, input int v, input int yy, input int d);
    chk({tag, " pending"}, int'(pending), p);
    chk({tag, " valid"}, int'(valid), v);
    if (v != 0) chk({tag, " y"}, int'(y), yy);
    chk({tag, " drop_cnt"}, int'(drop_cnt), d);
  endtask
  task automatic step(input logic r, input logic en, input logic [3:0] q, input logic rd);
    rst_n = r; e = en; req = q; ready = rd;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv.push_back('{1'b0, 1'b1, 4'hf, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0});
    tv.push_back('{1'b0, 1'b1, 4'hf, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h4, 1'b1, 4'h4, 1'b0, 2'd0, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'hb, 1'b1, 4'hb, 1'b0, 2'd2, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h3, 1'b1, 2'd3, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h1, 1'b1, 2'd1, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h8, 1'b0, 4'h8, 1'b0, 2'd0, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 2'd3, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h2, 1'b0, 4'h2, 1'b1, 2'd3, 8'd0});
    tv.push_back('{1'b1, 1'b1, 4'h2, 1'b0, 4'h2, 1'b1, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 8'd1});
    tv.push_back('{1'b1, 1'b0, 4'hf, 1'b1, 4'h0, 1'b0, 2'd1, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'hc, 1'b0, 4'hc, 1'b0, 2'd1, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b0, 4'h5, 1'b0, 4'h4, 1'b1, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h8, 1'b1, 4'h8, 1'b0, 2'd2, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 8'd1});
    tv.push_back('{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd3, 8'd1});
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst_n, tv[i].e, tv[i].req, tv[i].ready);
      chk_all($sformatf("vec%0d", i), int'(tv[i].p), int'(tv[i].v), int'(tv[i].y), int'(tv[i].d));
    end
    step(1'b1, 1'b1, 4'h1, 1'b0);
    chk_all("sat_capture", 1, 0, 0, 1);
    step(1'b1, 1'b1, 4'h1, 1'b0);
    chk_all("sat_load", 1, 1, 0, 1);
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b1, 4'h1, 1'b0);
      if (k == 10) chk_all("sat_k10", 1, 1, 0, 11);
    end
    chk_all("sat_300", 1, 1, 0, 255);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 4'h1, 1'b0);
    chk_all("sat_nowrap", 1, 1, 0, 255);
    step(1'b0, 1'b1, 4'h1, 1'b1);
    chk_all("rst_mid", 0, 0, 0, 0);
    chk("rst_mid y", int'(y), 0);
    step(1'b1, 1'b1, 4'h0, 1'b1);
    chk_all("rst_after", 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule

// File: doc/prio_encoder_4to2_seq.md
Name: prio_encoder_4to2_seq

Overview:
- Sequential priority encoder: the encode-side counterpart of the 2-to-4 decoder.
- Captures one-hot/multi-hot request pulses into a pending register. Emits the binary index of each pending request, one per handshake, highest index first.
- Sits in front of the decoder path: its y output feeds the decoder's select inputs, with e gating both ends.

Parameters:
- N, 4, number of request lines; power of 2, at least 2.
- W, 2, output code width; must equal clog2(N).
- CW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- e  input  1  enable; when 0, req is ignored and no new codes are issued.
- req  input  N  request pulses; bit i set means request for index i.
- y  output  W  encoded index; meaningful only while valid=1.
- valid  output  1  y holds an unconsumed code.
- ready  input  1  consumer accepts y this cycle when valid=1.
- pending  output  N  current pending-request register (registered).
- drop_cnt  output  CW  count of requests merged into an already-pending bit; saturates.

Behaviour:
- Reset: when rst_n=0 at a clk edge, pending, valid, y and drop_cnt all become 0. This takes priority over all other activity, including a mid-handshake transfer; any pending requests are discarded.
- Terms:
  - fire = valid & ready.
  - sel = index of the highest set bit of pending.
  - load = e & (|pending) & (~valid | ready).
- Output stage, per clk edge:
  - If load: valid<=1, y<=sel, and bit sel is cleared from pending.
  - Else if fire: valid<=0, y holds its value.
  - Else: hold.
- Pending update:
  - pending_next = (pending & ~clr) | (req & {N{e}}).
  - clr is the one-hot of sel when load, else 0.
  - Set wins over clear: a req on bit sel in the same cycle it is loaded is re-captured, and that is not a drop.
- Drop counting: drop_cnt increments by 1 for each cycle in which all of these hold:
  - e=1;
  - req & pending & ~clr is nonzero.
  - It counts one per cycle regardless of how many bits collide.
  - It saturates at 2^CW-1 and never wraps.
- Latency:
  - From idle, req at edge t appears in pending after edge t; valid=1 with y after edge t+1 (2 cycles).
  - With ready held at 1, one code is issued per cycle (back-to-back).
- Backpressure: while valid=1 and ready=0, y and valid hold stable, pending keeps accumulating, and no load occurs.
- e=0:
  - req is not captured and no load occurs.
  - An already-valid code still completes on fire, then valid drops to 0.
  - pending and drop_cnt hold.
- Empty pending with fire: valid drops to 0 the next cycle.
- Full pending (all ones): codes drain N-1, N-2, … 0 in that order, absent new requests.
- Higher index always wins; a low index can starve under a continuous high-index request. This is intended.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req=4'b1111, e=1 -> pending=0, valid=0, y=0, drop_cnt=0. Release rst_n; req=0 -> pending stays 0.
2. Single request: e=1, ready=1, one-cycle req=4'b0100 -> pending=4'b0100 after 1 cycle; valid=1, y=2 after 2 cycles; valid=0 on the next cycle.
3. Priority drain: req=4'b1011 for one cycle, ready=1 -> y sequence 3, 1, 0 on consecutive cycles, then valid=0 and pending=0.
4. Backpressure and merge: ready=0 while valid=1 with y=3; pulse req=4'b0010 twice -> drop_cnt=1, y stays 3. Raise ready -> next code is 1, then valid=0.
5. Enable gating: e=0, req=4'b1111 -> pending unchanged and no new valid. Set e=1 with req=0 -> no codes issued.
6. Same-cycle set/clear and saturation:
   - req=4'b1000 held while bit 3 is loaded each cycle -> y=3 issued every cycle, drop_cnt unchanged.
   - Then force 300 colliding cycles (ready=0, req=4'b0001 with bit 0 pending) -> drop_cnt=255.
   - Pulse rst_n low mid-transfer -> all outputs 0.
